uart_echo: RTL and testbench
============================

Name: uart_echo

Overview:
- Standalone serial echo block: receives 8N1 UART characters on RX, buffers them in a receive FIFO, and retransmits each byte unchanged on TX in arrival order.
- Sits at the top of the FPGA as the board-level serial loopback/echo endpoint, driven directly by the board clock and reset.
- Pure RTL; no processor.
- Sub-blocks: oversampling receiver, synchronous FIFO, transmitter.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- OVERSAMPLE, 16, receiver samples per bit.
- FIFO_DEPTH, 16, echo buffer entries; power of two, minimum 4.

Ports:
- CLK_IN  input  1  system clock; all logic on its rising edge.
- RESET_IN  input  1  asynchronous, active-low reset; assert async, deassert synchronised internally with a 2-flop synchroniser.
- RX  input  1  serial receive line, idle high, asynchronous to CLK_IN.
- TX  output  1  serial transmit line, idle high.

Behaviour:
- Baud tick: TICK_DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), which is 54 at the defaults. A free-running counter produces a 1-cycle tick every TICK_DIV clocks. TX uses one bit per OVERSAMPLE ticks.
- RX input: RX passes through a 2-flop synchroniser before use.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge on synchronised RX enters START.
  - START: re-samples at tick 7 (mid-bit). If the line is high, it is a glitch; return to IDLE with no output.
  - DATA: samples each bit at mid-bit (every 16 ticks).
  - STOP: samples at mid-bit. If 1, push the byte into the FIFO in that cycle. If 0 (framing error), discard the byte and wait for RX high before returning to IDLE.
- FIFO: synchronous, FIFO_DEPTH x 8, wrapping read/write pointers with one extra bit for full/empty detection.
  - Push when full: the new byte is dropped and stored contents are unchanged.
  - Simultaneous push and pop: both take effect; count unchanged.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE. Each state lasts exactly one bit time.
  - IDLE with FIFO not empty: pop and latch the byte, then drive the start bit on the next clock.
  - Latency from RX push to TX start bit is at most 2 clocks when TX is idle.
  - Back-to-back frames: after the stop bit, if the FIFO is not empty, the next start bit follows immediately with no extra idle bits.
- Reset values: TX = 1, both FSMs IDLE, FIFO empty, counters 0.
  - Reset asserted mid-frame aborts both frames immediately and drives TX high.
  - Partially received bytes and FIFO contents are lost.
- Throughput: TX and RX run at equal rates. A continuous 5-byte burst is echoed completely with at most 1 byte occupancy in the FIFO.

Optional Feature:
- Macro: UART_ECHO_UPCASE_EN.
- When defined, each received byte in 0x61..0x7A ('a'..'z') is converted to uppercase (bit 5 cleared) before the FIFO push. All other bytes pass unchanged.
- When undefined, bytes are echoed bit-exact.
- FIFO, timing and latency are identical in both builds.

Test Plan:
- Reset: hold RESET_IN=0 for 1000 ns, release -> TX stays 1 and no frames appear for at least 100 clocks.
- Echo burst: send "A","B","C","D","E" (0x41..0x45) back to back at 115200 -> TX emits 0x41..0x45 in order, each with a valid stop bit; the first start bit begins at most 2 clocks after the first RX stop-bit sample.
- Glitch/framing: a 2-tick low pulse on RX -> no TX output. A frame of 0x55 with stop bit = 0 -> no echo. The following 0x5A -> echoed correctly.
- Overflow: hold TX path busy by sending a continuous 20-byte stream -> all bytes echoed, none dropped (rates match). Force-fill the FIFO in an internal-FIFO test with 17 pushes and no pops -> the 17th byte is dropped and the first 16 read back in order.
- Mid-frame reset: assert RESET_IN during TX data bit 3 -> TX goes high asynchronously. After release, a new "Z" (0x5A) echoes correctly.
- Optional feature: with UART_ECHO_UPCASE_EN, send "a","z","{" -> echo 0x41, 0x5A, 0x7B. Without it -> echo 0x61, 0x7A, 0x7B.

Source files
------------

// File: rtl/uart_echo.sv
`timescale 1ns/1ps
// uart_echo -- board-level 8N1 serial echo endpoint.
//
// Every character received on RX is buffered in a small FIFO and sent back
// unchanged on TX, in arrival order.
//
// Ports:
//   CLK_IN    system clock, rising edge
//   RESET_IN  asynchronous active-low reset; release is synchronised internally
//   RX        serial input, idle high, asynchronous to CLK_IN
//   TX        serial output, idle high
//
// Optional build macro:
//   UART_ECHO_UPCASE_EN  fold 'a'..'z' to upper case before buffering.
//
// Also contains uart_echo_fifo, the FIFO that sits between receiver and transmitter.

// uart_echo_fifo -- synchronous 8-bit FIFO. The read data is always the head entry.
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata, empty.
// A push while full is dropped, leaving the stored contents unchanged.
module uart_echo_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic [7:0] rdata,
   output logic       empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        full;
   logic        push_ok;
   logic        pop_ok;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end
endmodule

module uart_echo #(
   parameter int unsigned CLK_HZ     = 100000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic CLK_IN,
   input  logic RESET_IN,
   input  logic RX,
   output logic TX
);
   localparam int unsigned TICK_DIV = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
   localparam int unsigned BIT_CLKS = TICK_DIV * OVERSAMPLE;
   localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned OW       = $clog2(OVERSAMPLE);
   localparam int unsigned BW       = $clog2(BIT_CLKS);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [OW-1:0] OS_MID    = OW'(OVERSAMPLE / 2 - 1);
   localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_CLKS - 1);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_FERR} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   // ---------------- reset and input synchronisation ----------------
   logic [1:0] rst_sync;
   logic       rst_n;

   always_ff @(posedge CLK_IN or negedge RESET_IN) begin
      if (!RESET_IN) rst_sync <= '0;
      else           rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   logic [1:0] rx_meta;
   logic       rx_s;
   logic       rx_prev;
   assign rx_s = rx_meta[1];

   always_ff @(posedge CLK_IN or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= '1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= {rx_meta[0], RX};
         rx_prev <= rx_s;
      end
   end

   // ---------------- oversampling tick ----------------
   logic [TW-1:0] tick_cnt;
   logic          tick;
   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge CLK_IN or negedge rst_n) begin
      if (!rst_n) tick_cnt <= '0;
      else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
   end

   // ---------------- receiver ----------------
   rx_state_t     rx_state, rx_next;
   logic [OW-1:0] rx_os, rx_os_n;
   logic [2:0]    rx_bit, rx_bit_n;
   logic [7:0]    rx_sh, rx_sh_n;
   logic          rx_push;

   always_ff @(posedge CLK_IN or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= RX_IDLE;
         rx_os    <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
      end else begin
         rx_state <= rx_next;
         rx_os    <= rx_os_n;
         rx_bit   <= rx_bit_n;
         rx_sh    <= rx_sh_n;
      end
   end

   always_comb begin
      rx_next  = rx_state;
      rx_os_n  = rx_os;
      rx_bit_n = rx_bit;
      rx_sh_n  = rx_sh;
      rx_push  = 1'b0;
      unique case (rx_state)
         RX_IDLE: begin
            if (rx_prev && !rx_s) begin
               rx_next = RX_START;
               rx_os_n = '0;
            end
         end
         RX_START: begin
            if (tick) begin
               if (rx_os == OS_MID) begin
                  // A line back high at mid start bit was only a glitch.
                  rx_os_n  = '0;
                  rx_bit_n = '0;
                  rx_next  = rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  rx_os_n = rx_os + 1'b1;
               end
            end
         end
         RX_DATA: begin
            if (tick) begin
               if (rx_os == OS_LAST) begin
                  rx_os_n  = '0;
                  rx_sh_n  = {rx_s, rx_sh[7:1]};
                  rx_bit_n = rx_bit + 1'b1;
                  if (rx_bit == 3'd7) rx_next = RX_STOP;
               end else begin
                  rx_os_n = rx_os + 1'b1;
               end
            end
         end
         RX_STOP: begin
            if (tick) begin
               if (rx_os == OS_LAST) begin
                  rx_os_n = '0;
                  if (rx_s) begin
                     rx_push = 1'b1;
                     rx_next = RX_IDLE;
                  end else begin
                     rx_next = RX_FERR;
                  end
               end else begin
                  rx_os_n = rx_os + 1'b1;
               end
            end
         end
         RX_FERR: begin
            // Framing error: drop the byte and hold off until the line idles.
            if (rx_s) rx_next = RX_IDLE;
         end
         default: rx_next = RX_IDLE;
      endcase
   end

   logic [7:0] fifo_wdata;
`ifdef UART_ECHO_UPCASE_EN
   assign fifo_wdata = (rx_sh >= 8'h61 && rx_sh <= 8'h7A) ? (rx_sh & 8'hDF) : rx_sh;
`else
   assign fifo_wdata = rx_sh;
`endif

   // ---------------- echo buffer ----------------
   logic [7:0] fifo_rdata;
   logic       fifo_empty;
   logic       tx_pop;

   uart_echo_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (CLK_IN),
      .rst_n (rst_n),
      .push  (rx_push),
      .wdata (fifo_wdata),
      .pop   (tx_pop),
      .rdata (fifo_rdata),
      .empty (fifo_empty)
   );

   // ---------------- transmitter ----------------
   // Bit timing counts clocks directly so every bit is exactly one bit time,
   // independent of where the free-running tick happens to be.
   tx_state_t     tx_state, tx_next;
   logic [BW-1:0] tx_cnt, tx_cnt_n;
   logic [2:0]    tx_bit, tx_bit_n;
   logic [7:0]    tx_sh, tx_sh_n;
   logic          tx_q, tx_n;
   logic          bit_end;

   assign bit_end = (tx_cnt == BIT_LAST);
   assign TX      = tx_q;

   always_ff @(posedge CLK_IN or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_sh    <= '0;
         tx_q     <= 1'b1;
      end else begin
         tx_state <= tx_next;
         tx_cnt   <= tx_cnt_n;
         tx_bit   <= tx_bit_n;
         tx_sh    <= tx_sh_n;
         tx_q     <= tx_n;
      end
   end

   always_comb begin
      tx_next  = tx_state;
      tx_cnt_n = tx_cnt + 1'b1;
      tx_bit_n = tx_bit;
      tx_sh_n  = tx_sh;
      tx_n     = tx_q;
      tx_pop   = 1'b0;
      unique case (tx_state)
         TX_IDLE: begin
            tx_cnt_n = '0;
            tx_n     = 1'b1;
            if (!fifo_empty) begin
               tx_pop  = 1'b1;
               tx_sh_n = fifo_rdata;
               tx_n    = 1'b0;
               tx_next = TX_START;
            end
         end
         TX_START: begin
            if (bit_end) begin
               tx_cnt_n = '0;
               tx_bit_n = '0;
               tx_n     = tx_sh[0];
               tx_next  = TX_DATA;
            end
         end
         TX_DATA: begin
            if (bit_end) begin
               tx_cnt_n = '0;
               tx_sh_n  = {1'b0, tx_sh[7:1]};
               if (tx_bit == 3'd7) begin
                  tx_n    = 1'b1;
                  tx_next = TX_STOP;
               end else begin
                  tx_n     = tx_sh[1];
                  tx_bit_n = tx_bit + 1'b1;
               end
            end
         end
         TX_STOP: begin
            if (bit_end) begin
               tx_cnt_n = '0;
               // Chain straight into the next start bit when more data waits.
               if (!fifo_empty) begin
                  tx_pop  = 1'b1;
                  tx_sh_n = fifo_rdata;
                  tx_n    = 1'b0;
                  tx_next = TX_START;
               end else begin
                  tx_n    = 1'b1;
                  tx_next = TX_IDLE;
               end
            end
         end
         default: tx_next = TX_IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_echo.sv
`timescale 1ns/1ps
// tb_uart_echo -- self-checking bench for uart_echo and its internal FIFO.
// Runs the echo at a reduced clock rate so each bit is 32 clocks long.
module tb_uart_echo;
   localparam int unsigned CLK_HZ   = 3686400;
   localparam int unsigned BAUD     = 115200;
   localparam int unsigned OS       = 16;
   localparam int unsigned DEPTH    = 16;
   localparam int unsigned TICK_DIV = (CLK_HZ + (BAUD * OS) / 2) / (BAUD * OS);
   localparam int unsigned BIT      = TICK_DIV * OS;
   localparam int unsigned FRAME    = 10 * BIT;

   logic CLK_IN   = 1'b0;
   logic RESET_IN = 1'b0;
   logic RX       = 1'b1;
   logic TX;

   logic       f_rst_n = 1'b0;
   logic       f_push  = 1'b0;
   logic       f_pop   = 1'b0;
   logic [7:0] f_wdata = 8'h00;
   logic [7:0] f_rdata;
   logic       f_empty;

   always #5 CLK_IN = ~CLK_IN;

   uart_echo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
      .CLK_IN   (CLK_IN),
      .RESET_IN (RESET_IN),
      .RX       (RX),
      .TX       (TX)
   );

   uart_echo_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (CLK_IN),
      .rst_n (f_rst_n),
      .push  (f_push),
      .wdata (f_wdata),
      .pop   (f_pop),
      .rdata (f_rdata),
      .empty (f_empty)
   );

   int unsigned cyc = 0;
   always @(posedge CLK_IN) cyc <= cyc + 1;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int unsigned act,
                              input int unsigned lo, input int unsigned hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Reference behaviour: the byte that should come back for a received byte.
   function automatic logic [7:0] model_echo(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
      if (b >= 8'h61 && b <= 8'h7A) return b - 8'd32;
`endif
      return b;
   endfunction

   // ---------------- TX line monitor ----------------
   typedef struct {
      logic [7:0]  data;
      logic        stop;
      int unsigned start_cyc;
   } frame_t;
   frame_t mon_q[$];

   initial begin : monitor
      frame_t     f;
      logic [7:0] d;
      forever begin
         @(negedge CLK_IN);
         if (TX === 1'b0) begin
            f.start_cyc = cyc;
            repeat (BIT / 2) @(negedge CLK_IN);
            if (TX === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (BIT) @(negedge CLK_IN);
                  d[i] = TX;
               end
               repeat (BIT) @(negedge CLK_IN);
               f.data = d;
               f.stop = TX;
               mon_q.push_back(f);
            end
         end
      end
   end

   // Must be entered right at a rising edge; returns at a rising edge, so
   // consecutive calls produce back-to-back frames.
   task automatic send_byte(input logic [7:0] d, input logic stop, output int unsigned fall_cyc);
      #1;
      RX = 1'b0;
      fall_cyc = cyc;
      for (int i = 0; i < 8; i++) begin
         repeat (BIT) @(posedge CLK_IN);
         #1;
         RX = d[i];
      end
      repeat (BIT) @(posedge CLK_IN);
      #1;
      RX = stop;
      repeat (BIT) @(posedge CLK_IN);
   endtask

   task automatic wait_echo(input int n, input int unsigned budget);
      int unsigned k = 0;
      while (mon_q.size() < n && k < budget) begin
         @(posedge CLK_IN);
         k++;
      end
      repeat (2 * FRAME) @(posedge CLK_IN);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       echo;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[10];

   initial begin : watchdog
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0]  exp_q[$];
      logic [7:0]  fq[$];
      logic [7:0]  b;
      int unsigned fc, first_fall, lows;

      tbl[0] = '{8'h41, 1'b1, 1'b1, 8'h41};
      tbl[1] = '{8'h42, 1'b1, 1'b1, 8'h42};
      tbl[2] = '{8'h43, 1'b1, 1'b1, 8'h43};
      tbl[3] = '{8'h44, 1'b1, 1'b1, 8'h44};
      tbl[4] = '{8'h45, 1'b1, 1'b1, 8'h45};
      tbl[5] = '{8'h55, 1'b0, 1'b0, 8'h00};
      tbl[6] = '{8'h5A, 1'b1, 1'b1, 8'h5A};
`ifdef UART_ECHO_UPCASE_EN
      tbl[7] = '{8'h61, 1'b1, 1'b1, 8'h41};
      tbl[8] = '{8'h7A, 1'b1, 1'b1, 8'h5A};
`else
      tbl[7] = '{8'h61, 1'b1, 1'b1, 8'h61};
      tbl[8] = '{8'h7A, 1'b1, 1'b1, 8'h7A};
`endif
      tbl[9] = '{8'h7B, 1'b1, 1'b1, 8'h7B};

      // ---- reset ----
      #500;
      check("tx_during_reset", 32'(TX), 32'h1);
      #500;
      RESET_IN = 1'b1;
      lows = 0;
      repeat (100) begin
         @(negedge CLK_IN);
         if (TX !== 1'b1) lows++;
      end
      check("reset_idle_low_cycles", lows, 0);
      check("reset_no_frames", mon_q.size(), 0);

      // ---- 2-tick glitch ----
      @(posedge CLK_IN);
      #1 RX = 1'b0;
      repeat (2 * TICK_DIV) @(posedge CLK_IN);
      #1 RX = 1'b1;
      repeat (2 * FRAME) @(posedge CLK_IN);
      check("glitch_no_echo", mon_q.size(), 0);

      // ---- table: burst, framing error, recovery, case folding ----
      first_fall = 0;
      for (int i = 0; i < 10; i++) begin
         send_byte(tbl[i].data, tbl[i].stop, fc);
         if (i == 0) first_fall = fc;
         if (!tbl[i].stop) begin
            #1 RX = 1'b1;
            repeat (BIT) @(posedge CLK_IN);
         end
         if (tbl[i].echo) exp_q.push_back(tbl[i].exp);
      end
      wait_echo(exp_q.size(), 4 * FRAME);
      check("table_echo_count", mon_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size(); j++) begin
         if (j < mon_q.size()) begin
            check($sformatf("table_data[%0d]", j), 32'(mon_q[j].data), 32'(exp_q[j]));
            check($sformatf("table_stop[%0d]", j), 32'(mon_q[j].stop), 32'h1);
         end
      end
      if (mon_q.size() >= 5) begin
         check_range("first_start_latency", mon_q[0].start_cyc - first_fall,
                     9 * BIT + BIT / 2, 9 * BIT + BIT / 2 + 5 + 2 * TICK_DIV);
         for (int j = 1; j < 5; j++)
            check($sformatf("burst_spacing[%0d]", j),
                  mon_q[j].start_cyc - mon_q[j-1].start_cyc, FRAME);
      end

      // ---- continuous random stream ----
      mon_q.delete();
      exp_q.delete();
      for (int i = 0; i < 20; i++) begin
         b = 8'($urandom);
         send_byte(b, 1'b1, fc);
         exp_q.push_back(model_echo(b));
      end
      wait_echo(exp_q.size(), 4 * FRAME);
      check("stream_echo_count", mon_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size(); j++) begin
         if (j < mon_q.size()) begin
            check($sformatf("stream_data[%0d]", j), 32'(mon_q[j].data), 32'(exp_q[j]));
            check($sformatf("stream_stop[%0d]", j), 32'(mon_q[j].stop), 32'h1);
         end
      end

      // ---- reset during TX data bit 3 ----
      mon_q.delete();
      send_byte(8'h00, 1'b1, fc);
      fc = 0;
      while (TX !== 1'b0 && fc < 2 * FRAME) begin
         @(negedge CLK_IN);
         fc++;
      end
      check("midreset_tx_started", 32'(TX), 32'h0);
      repeat (4 * BIT) @(negedge CLK_IN);
      check("midreset_bit3_low", 32'(TX), 32'h0);
      #1 RESET_IN = 1'b0;
      #1;
      check("midreset_tx_async_high", 32'(TX), 32'h1);
      #100 RESET_IN = 1'b1;
      repeat (FRAME + 2 * BIT) @(posedge CLK_IN);
      check("midreset_tx_idle", 32'(TX), 32'h1);
      mon_q.delete();
      send_byte(8'h5A, 1'b1, fc);
      wait_echo(1, 4 * FRAME);
      check("midreset_echo_count", mon_q.size(), 1);
      if (mon_q.size() > 0) begin
         check("midreset_echo_data", 32'(mon_q[0].data), 32'h5A);
         check("midreset_echo_stop", 32'(mon_q[0].stop), 32'h1);
      end

      // ---- FIFO overflow and simultaneous push/pop ----
      @(posedge CLK_IN);
      #1;
      check("fifo_empty_in_reset", 32'(f_empty), 32'h1);
      f_rst_n = 1'b1;
      @(posedge CLK_IN);
      #1;
      for (int i = 0; i < 17; i++) begin
         f_push  = 1'b1;
         f_wdata = (i == 16) ? ~fq[0] : 8'($urandom);
         if (i < 16) fq.push_back(f_wdata);
         @(posedge CLK_IN);
         #1;
      end
      f_push = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("fifo_rd[%0d]", i), 32'(f_rdata), 32'(fq[i]));
         f_pop = 1'b1;
         @(posedge CLK_IN);
         #1;
      end
      f_pop = 1'b0;
      check("fifo_empty_after_16", 32'(f_empty), 32'h1);
      f_push  = 1'b1;
      f_wdata = 8'hA5;
      @(posedge CLK_IN);
      #1;
      f_wdata = 8'h3C;
      f_pop   = 1'b1;
      check("fifo_head_before_pushpop", 32'(f_rdata), 32'hA5);
      @(posedge CLK_IN);
      #1;
      f_push = 1'b0;
      f_pop  = 1'b0;
      check("fifo_head_after_pushpop", 32'(f_rdata), 32'h3C);
      check("fifo_not_empty_after_pushpop", 32'(f_empty), 32'h0);
      f_pop = 1'b1;
      @(posedge CLK_IN);
      #1;
      f_pop = 1'b0;
      check("fifo_empty_final", 32'(f_empty), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
